// File: rtl/bus_timeout_monitor_pkg.sv
// ---------------------------------------------------------------------------
// busMonitorPkg
// Shared definitions for the bus timeout monitor: FSM state encoding,
// custom-instruction command codes, the timeout counter width and a small
// helper that packs the status word returned by the status read command.
// ---------------------------------------------------------------------------
package busMonitorPkg;

    localparam int TIMEOUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam logic [1:0] CI_A_READ_FAULT  = 2'd0;
    localparam logic [1:0] CI_A_READ_LIMIT  = 2'd1;
    localparam logic [1:0] CI_A_WRITE_LIMIT = 2'd2;
    localparam logic [1:0] CI_A_READ_STATUS = 2'd3;

    // Status word: bit 1 = sticky fault flag, bit 0 = transaction in flight.
    function automatic logic [31:0] pack_status(input logic sticky, input logic active);
        return {30'd0, sticky, active};
    endfunction

endpackage

// File: rtl/bus_timeout_monitor_counter.sv
// ---------------------------------------------------------------------------
// timeoutCounter
// Loadable cycle counter for one bus transaction. A load snapshots the
// limit for the new transaction and zeroes the count; clear zeroes the
// count; enable advances it. expire is high on the last permitted cycle,
// i.e. when count == limit - 1. The count never wraps because the owning
// FSM stops enabling it once expire is seen.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load        - start of transaction: capture load_limit, count <= 0
//   clear       - count <= 0
//   enable      - count <= count + 1
//   load_limit  - limit to capture on load
//   expire      - count has reached limit - 1
// ---------------------------------------------------------------------------
module timeoutCounter
    import busMonitorPkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [TIMEOUT_WIDTH-1:0] load_limit,
    output logic                     expire
);

    logic [TIMEOUT_WIDTH-1:0] count_r;
    logic [TIMEOUT_WIDTH-1:0] active_limit_r;

    // Count register and the limit snapshot of the running transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r        <= 16'd0;
            active_limit_r <= 16'd0;
        end else if (load) begin
            count_r        <= 16'd0;
            active_limit_r <= load_limit;
        end else if (clear) begin
            count_r        <= 16'd0;
        end else if (enable) begin
            count_r        <= count_r + 16'd1;
        end
    end

    // Expiry compare against the snapshot; only meaningful while a transaction runs.
    always_comb begin
        expire = (count_r == (active_limit_r - 16'd1));
    end

endmodule

// File: rtl/bus_timeout_monitor.sv
// ---------------------------------------------------------------------------
// bus_timeout_monitor
// Bus watchdog. Times every transaction against a programmable cycle limit
// and, on expiry, emits a one-cycle busErrorOut together with a forced
// endTransactionOut. The faulting address and the limit are accessed by
// software through the custom-instruction port.
//
// Ports:
//   systemClock, reset       - clock, asynchronous active-high reset
//   beginTransactionIn       - transaction start pulse, address on addressDataIn
//   endTransactionIn         - normal completion pulse
//   busErrorIn               - slave error, ends the transaction without timeout
//   addressDataIn[31:0]      - transaction address
//   busErrorOut              - registered timeout pulse
//   endTransactionOut        - registered forced-end pulse, same cycle as busErrorOut
//   ciStart, ciCke, ciN      - custom-instruction handshake and id
//   ciValueA, ciValueB       - command (A[1:0]) and write operand (B[15:0])
//   ciResult, ciDone         - combinational custom-instruction response
// ---------------------------------------------------------------------------
module bus_timeout_monitor
    import busMonitorPkg::*;
#(
    parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter logic [15:0] DEFAULT_TIMEOUT       = 16'd1024
) (
    input  logic        systemClock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    input  logic [31:0] addressDataIn,
    output logic        busErrorOut,
    output logic        endTransactionOut,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone
);

    state_t                   state_r;
    logic [TIMEOUT_WIDTH-1:0] limit_r;
    logic [31:0]              pending_address_r;
    logic [31:0]              fault_address_r;
    logic                     sticky_fault_r;

    logic       in_idle_s;
    logic       in_active_s;
    logic       end_seen_s;
    logic       expire_s;
    logic       cnt_load_s;
    logic       cnt_clear_s;
    logic       cnt_enable_s;
    logic       is_my_ci_s;
    logic [1:0] ci_cmd_s;
    logic       ci_read_fault_s;
    logic       ci_write_limit_s;
    logic       ci_unused_bits_s;

    // Only the command field of A and the low half of B carry meaning.
    assign ci_unused_bits_s = ^{ciValueA[31:2], ciValueB[31:16]};

    // Decode of state, transaction events and custom-instruction commands.
    always_comb begin
        in_idle_s        = (state_r == IDLE);
        in_active_s      = (state_r == ACTIVE);
        end_seen_s       = endTransactionIn | busErrorIn;
        // Load happens on any begin seen in IDLE, even with limit 0.
        cnt_load_s       = in_idle_s & beginTransactionIn;
        cnt_clear_s      = in_active_s & (end_seen_s | expire_s);
        cnt_enable_s     = in_active_s & ~end_seen_s & ~expire_s;
        is_my_ci_s       = (ciN == CUSTOM_INSTRUCTION_ID) & ciStart & ciCke;
        ci_cmd_s         = ciValueA[1:0];
        ci_read_fault_s  = is_my_ci_s & (ci_cmd_s == CI_A_READ_FAULT);
        ci_write_limit_s = is_my_ci_s & (ci_cmd_s == CI_A_WRITE_LIMIT);
    end

    timeoutCounter u_counter (
        .clk        (systemClock),
        .rst        (reset),
        .load       (cnt_load_s),
        .clear      (cnt_clear_s),
        .enable     (cnt_enable_s),
        .load_limit (limit_r),
        .expire     (expire_s)
    );

    // Transaction FSM with registered error outputs and software-visible registers.
    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            busErrorOut       <= 1'b0;
            endTransactionOut <= 1'b0;
            limit_r           <= DEFAULT_TIMEOUT;
            pending_address_r <= 32'd0;
            fault_address_r   <= 32'd0;
            sticky_fault_r    <= 1'b0;
        end else begin
            busErrorOut       <= 1'b0;
            endTransactionOut <= 1'b0;

            // A write here lands after any begin in this cycle latched the old limit.
            if (ci_write_limit_s) begin
                limit_r <= ciValueB[TIMEOUT_WIDTH-1:0];
            end else begin
                limit_r <= limit_r;
            end

            // Setting the sticky flag dominates a same-cycle software clear.
            if (state_r == ERROR) begin
                sticky_fault_r <= 1'b1;
            end else if (ci_read_fault_s) begin
                sticky_fault_r <= 1'b0;
            end else begin
                sticky_fault_r <= sticky_fault_r;
            end

            case (state_r)
                IDLE: begin
                    if (beginTransactionIn) begin
                        pending_address_r <= addressDataIn;
                        if (limit_r != 16'd0) begin
                            state_r <= ACTIVE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACTIVE: begin
                    // Normal end or slave error beats an expiring timeout.
                    if (end_seen_s) begin
                        state_r <= IDLE;
                    end else if (expire_s) begin
                        state_r           <= ERROR;
                        busErrorOut       <= 1'b1;
                        endTransactionOut <= 1'b1;
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                ERROR: begin
                    // Any begin arriving here is dropped.
                    fault_address_r <= pending_address_r;
                    state_r         <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Custom-instruction read mux; zero whenever the instruction is not ours.
    always_comb begin
        ciResult = 32'd0;
        if (is_my_ci_s) begin
            case (ci_cmd_s)
                CI_A_READ_FAULT:  ciResult = fault_address_r;
                CI_A_READ_LIMIT:  ciResult = {16'd0, limit_r};
                CI_A_WRITE_LIMIT: ciResult = 32'd0;
                CI_A_READ_STATUS: ciResult = pack_status(sticky_fault_r, in_active_s);
                default:          ciResult = 32'd0;
            endcase
        end else begin
            ciResult = 32'd0;
        end
    end

    assign ciDone = is_my_ci_s;

endmodule

// File: tb/tb_bus_timeout_monitor.sv
// ---------------------------------------------------------------------------
// tb_bus_timeout_monitor
// Directed scenarios plus a randomized run against a transaction-level
// reference model: a transaction started at edge k with limit L times out
// at edge k+L unless ended earlier; the error cycle then records the fault.
// ---------------------------------------------------------------------------
module tb_bus_timeout_monitor;

    logic        systemClock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busErrorIn = 1'b0;
    logic [31:0] addressDataIn = 32'd0;
    logic        busErrorOut;
    logic        endTransactionOut;
    logic        ciStart = 1'b0;
    logic        ciCke = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0;
    logic [31:0] ciValueB = 32'd0;
    logic [31:0] ciResult;
    logic        ciDone;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          edge_n = 0;
    bit          m_busy = 1'b0;
    int          m_deadline = 0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_fault = 32'd0;
    bit          m_sticky = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_limit = 16'd1024;
    int          rises = 0;
    bit          prev_err = 1'b0;

    bus_timeout_monitor dut (
        .systemClock        (systemClock),
        .reset              (reset),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .busErrorIn         (busErrorIn),
        .addressDataIn      (addressDataIn),
        .busErrorOut        (busErrorOut),
        .endTransactionOut  (endTransactionOut),
        .ciStart            (ciStart),
        .ciCke              (ciCke),
        .ciN                (ciN),
        .ciValueA           (ciValueA),
        .ciValueB           (ciValueB),
        .ciResult           (ciResult),
        .ciDone             (ciDone)
    );

    always #5 systemClock = ~systemClock;

    function automatic bit ci_hit();
        return ciStart && ciCke && (ciN == 8'd0);
    endfunction

    function automatic logic [31:0] ci_expect();
        if (!ci_hit()) return 32'd0;
        case (ciValueA[1:0])
            2'd0:    return m_fault;
            2'd1:    return {16'd0, m_limit};
            2'd3:    return {30'd0, m_sticky, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_err = 1'b0; m_fault = 32'd0; m_sticky = 1'b0;
        m_limit = 16'd1024; m_addr = 32'd0; prev_err = 1'b0;
    endtask

    // Set inputs right after an edge, then move to mid-cycle for sampling.
    task automatic drive(input bit b, input bit e, input bit be, input logic [31:0] addr,
                         input bit ci, input logic [1:0] cmd, input logic [31:0] vb);
        beginTransactionIn = b; endTransactionIn = e; busErrorIn = be;
        addressDataIn = addr; ciStart = ci; ciCke = ci; ciN = 8'd0;
        ciValueA = {30'd0, cmd}; ciValueB = vb;
        #4;
    endtask

    // Advance the model by the coming edge, then wait for that edge.
    task automatic tick();
        bit hit;
        bit new_err;
        logic [15:0] lim_old;
        hit = ci_hit();
        new_err = 1'b0;
        lim_old = m_limit;
        if (busErrorOut === 1'b1 && !prev_err) rises++;
        prev_err = (busErrorOut === 1'b1);
        if (hit && ciValueA[1:0] == 2'd2) m_limit = ciValueB[15:0];
        if (hit && ciValueA[1:0] == 2'd0) m_sticky = 1'b0;
        if (m_err) begin
            m_fault = m_addr;
            m_sticky = 1'b1;
        end else if (m_busy) begin
            if (endTransactionIn || busErrorIn) begin
                m_busy = 1'b0;
            end else if (edge_n == m_deadline) begin
                m_busy = 1'b0;
                new_err = 1'b1;
            end
        end else if (beginTransactionIn && lim_old != 16'd0) begin
            m_busy = 1'b1;
            m_deadline = edge_n + int'(lim_old);
            m_addr = addressDataIn;
        end
        m_err = new_err;
        @(posedge systemClock);
        #1;
        edge_n++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        beginTransactionIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0;
        ciStart = 1'b0; ciCke = 1'b0;
        model_reset();
        repeat (2) @(posedge systemClock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (busErrorOut !== 1'b0 || endTransactionOut !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got err=%b end=%b expected 0 0", busErrorOut, endTransactionOut);
        end
        apply_reset();
        drive(0, 0, 0, 32'd0, 1, 2'd1, 32'd0);
        checks++;
        if (ciDone !== 1'b1 || ciResult !== 32'd1024) begin
            failures++;
            $display("FAIL reset_limit: got done=%b result=%0d expected 1 1024", ciDone, ciResult);
        end
        checks++;
        if (busErrorOut !== 1'b0 || endTransactionOut !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_outputs: got err=%b end=%b expected 0 0", busErrorOut, endTransactionOut);
        end
        tick();
        drive(0, 0, 0, 32'd0, 0, 2'd1, 32'd0);
        checks++;
        if (ciDone !== 1'b0 || ciResult !== 32'd0) begin
            failures++;
            $display("FAIL ci_not_selected: got done=%b result=%0h expected 0 0", ciDone, ciResult);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive(0, 0, 0, 32'd0, 1, 2'd2, 32'd5);
        tick();
        drive(1, 0, 0, 32'h8000_0010, 0, 2'd0, 32'd0);
        tick();
        for (int c = 0; c < 6; c++) begin
            // A begin during the error cycle must be dropped.
            drive(c == 5, 0, 0, 32'hDEAD_BEEF, c == 2, 2'd3, 32'd0);
            checks++;
            if (busErrorOut !== (c == 5) || endTransactionOut !== (c == 5)) begin
                failures++;
                $display("FAIL timeout_pulse c=%0d: got err=%b end=%b expected %b", c, busErrorOut, endTransactionOut, c == 5);
            end
            if (c == 2) begin
                checks++;
                if (ciResult !== 32'd1) begin
                    failures++;
                    $display("FAIL status_active: got %0h expected 1", ciResult);
                end
            end
            tick();
        end
        drive(0, 0, 0, 32'd0, 1, 2'd3, 32'd0);
        checks++;
        if (ciResult !== 32'd2) begin
            failures++;
            $display("FAIL status_after_error: got %0h expected 2", ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd0, 32'd0);
        checks++;
        if (ciResult !== 32'h8000_0010) begin
            failures++;
            $display("FAIL fault_address: got %0h expected 80000010", ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd3, 32'd0);
        checks++;
        if (ciResult !== 32'd0) begin
            failures++;
            $display("FAIL sticky_cleared: got %0h expected 0", ciResult);
        end
        tick();
    endtask

    task automatic test_normal_end();
        drive(1, 0, 0, 32'h1111_2222, 0, 2'd0, 32'd0);
        tick();
        for (int c = 0; c < 7; c++) begin
            drive(0, c == 4, 0, 32'd0, 0, 2'd0, 32'd0);
            checks++;
            if (busErrorOut !== 1'b0) begin
                failures++;
                $display("FAIL end_at_limit c=%0d: got err=%b expected 0", c, busErrorOut);
            end
            tick();
        end
        drive(0, 0, 0, 32'd0, 1, 2'd3, 32'd0);
        checks++;
        if (ciResult !== 32'd0) begin
            failures++;
            $display("FAIL end_status: got %0h expected 0", ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd0, 32'd0);
        checks++;
        if (ciResult !== 32'h8000_0010) begin
            failures++;
            $display("FAIL end_fault_kept: got %0h expected 80000010", ciResult);
        end
        tick();
    endtask

    task automatic test_disabled();
        int pulses;
        pulses = 0;
        drive(0, 0, 0, 32'd0, 1, 2'd2, 32'd0);
        tick();
        drive(1, 0, 0, 32'h2222_3333, 0, 2'd0, 32'd0);
        tick();
        for (int c = 0; c < 5000; c++) begin
            drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
            if (busErrorOut !== 1'b0) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL disabled_no_error: got %0d pulse cycles expected 0", pulses);
        end
        drive(0, 0, 0, 32'd0, 1, 2'd3, 32'd0);
        checks++;
        if (ciResult !== 32'd0) begin
            failures++;
            $display("FAIL disabled_status: got %0h expected 0", ciResult);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [11:0] seen;
        int rises0;
        drive(0, 0, 0, 32'd0, 1, 2'd2, 32'd3);
        tick();
        rises0 = rises;
        seen = 12'd0;
        for (int i = 0; i < 12; i++) begin
            drive(i == 0 || i == 5, 0, 0, 32'h3000_0000 + 32'(i), 0, 2'd0, 32'd0);
            seen[i] = busErrorOut;
            tick();
        end
        checks++;
        if (seen !== 12'b0010_0001_0000) begin
            failures++;
            $display("FAIL back_to_back_pattern: got %b expected 001000010000", seen);
        end
        checks++;
        if (rises - rises0 != 2) begin
            failures++;
            $display("FAIL back_to_back_count: got %0d expected 2", rises - rises0);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        drive(1, 0, 0, 32'hAAAA_0001, 0, 2'd0, 32'd0);
        tick();
        repeat (5) begin
            drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
            tick();
        end
        drive(1, 0, 0, 32'hBBBB_0002, 0, 2'd0, 32'd0);
        tick();
        repeat (3) begin
            drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
            tick();
        end
        drive(0, 0, 0, 32'd0, 1, 2'd0, 32'd0);
        checks++;
        if (busErrorOut !== 1'b1 || ciResult !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL read_in_error: got err=%b result=%0h expected 1 aaaa0001", busErrorOut, ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd3, 32'd0);
        checks++;
        if (ciResult !== 32'd2) begin
            failures++;
            $display("FAIL sticky_dominates: got %0h expected 2", ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd0, 32'd0);
        checks++;
        if (ciResult !== 32'hBBBB_0002) begin
            failures++;
            $display("FAIL fault_second: got %0h expected bbbb0002", ciResult);
        end
        tick();
        // Write of 7 alongside a begin: this transaction still uses limit 3.
        drive(1, 0, 0, 32'hCCCC_0003, 1, 2'd2, 32'd7);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
            checks++;
            if (busErrorOut !== (c == 3)) begin
                failures++;
                $display("FAIL old_limit_latched c=%0d: got %b expected %b", c, busErrorOut, c == 3);
            end
            tick();
        end
        drive(0, 0, 0, 32'd0, 1, 2'd1, 32'd0);
        checks++;
        if (ciResult !== 32'd7) begin
            failures++;
            $display("FAIL new_limit: got %0d expected 7", ciResult);
        end
        tick();
        drive(0, 0, 0, 32'd0, 1, 2'd2, 32'd5);
        tick();
        drive(1, 0, 0, 32'hDDDD_0004, 0, 2'd0, 32'd0);
        tick();
        drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
        tick();
        tick();
        apply_reset();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
            if (busErrorOut !== 1'b0) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_transaction: got %0d pulse cycles expected 0", pulses);
        end
        drive(0, 0, 0, 32'd0, 1, 2'd1, 32'd0);
        checks++;
        if (ciResult !== 32'd1024) begin
            failures++;
            $display("FAIL reset_restores_limit: got %0d expected 1024", ciResult);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_r;
        for (int i = 0; i < 3000; i++) begin
            beginTransactionIn = ($urandom_range(3) == 0);
            endTransactionIn = ($urandom_range(7) == 0);
            busErrorIn = ($urandom_range(15) == 0);
            addressDataIn = $urandom;
            ciStart = ($urandom_range(3) == 0);
            ciCke = ($urandom_range(7) != 0);
            ciN = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'd0;
            ciValueA = $urandom;
            ciValueB = {16'($urandom_range(65535)), 16'($urandom_range(6))};
            #4;
            exp_r = ci_expect();
            checks++;
            if (busErrorOut !== m_err || endTransactionOut !== m_err) begin
                failures++;
                $display("FAIL rand_error i=%0d: got err=%b end=%b expected %b", i, busErrorOut, endTransactionOut, m_err);
            end
            checks++;
            if (ciDone !== ci_hit()) begin
                failures++;
                $display("FAIL rand_done i=%0d: got %b expected %b", i, ciDone, ci_hit());
            end
            checks++;
            if (ciResult !== exp_r) begin
                failures++;
                $display("FAIL rand_result i=%0d: got %0h expected %0h", i, ciResult, exp_r);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_normal_end();
        test_disabled();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_timeout_monitor.md
# bus_timeout_monitor

Bus watchdog that sits directly upstream of the bus error counter. It observes every bus transaction and, when a transaction exceeds a programmable cycle limit, raises a one-cycle error that also forces the transaction to end. Its `busErrorOut` drives the counter's `busErrorIn`. Software reads the faulting address and programs the limit through the custom-instruction interface.

## Interface
Parameters:
- `CUSTOM_INSTRUCTION_ID`, default 8'd0: ciN value this block answers.
- `DEFAULT_TIMEOUT`, default 16'd1024: cycle limit loaded at reset; 0 disables the watchdog.

Ports:
- `systemClock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `beginTransactionIn` in 1: start of a bus transaction, one-cycle pulse.
- `endTransactionIn` in 1: normal completion, one-cycle pulse.
- `busErrorIn` in 1: slave-reported error; terminates the transaction with no timeout.
- `addressDataIn` in 32: address, valid when `beginTransactionIn` is high.
- `busErrorOut` out 1: timeout error pulse, registered.
- `endTransactionOut` out 1: forced end pulse, registered, coincident with `busErrorOut`.
- `ciStart`, `ciCke` in 1 each; `ciN` in 8; `ciValueA`, `ciValueB` in 32; `ciResult` out 32; `ciDone` out 1.

## Operation
- Reset values: `busErrorOut`=0, `endTransactionOut`=0, `state`=IDLE, `count`=0, `faultAddress`=0, `stickyFault`=0, `limit`=`DEFAULT_TIMEOUT`.
- **IDLE:**
  - On `beginTransactionIn`: latch `addressDataIn` into `pendingAddress`, latch `limit` into `activeLimit`, set `count`=0.
  - Go to ACTIVE, unless `limit`==0; in that case stay IDLE.
- **ACTIVE:**
  - `endTransactionIn` or `busErrorIn` returns the block to IDLE with no error. End/error wins over an expiring timeout in the same cycle.
  - Otherwise, when `count`==`activeLimit`-1, go to ERROR.
  - Otherwise `count`+1. `count` is 16 bits and never wraps, because it is bounded by `activeLimit`.
- **ERROR** (one cycle):
  - `busErrorOut`=1 and `endTransactionOut`=1.
  - `faultAddress`←`pendingAddress`, `stickyFault`←1.
  - Next state is always IDLE.
  - `beginTransactionIn` in this cycle is ignored (protocol violation).
- `beginTransactionIn` while ACTIVE is ignored; the original transaction keeps timing.
- **Custom instruction:**
  - `isMyCi` = (`ciN`==`CUSTOM_INSTRUCTION_ID`) & `ciStart` & `ciCke`.
  - `ciDone`=`isMyCi`, combinational.
  - `ciResult`=0 when not `isMyCi`.
- **Commands, selected by `ciValueA[1:0]`:**
  - 0: read `faultAddress`; clears `stickyFault`.
  - 1: read {16'd0, `limit`}.
  - 2: `limit`←`ciValueB[15:0]`; result 0. Takes effect at the next `beginTransactionIn`, never mid-transaction.
  - 3: read {30'd0, `stickyFault`, state==ACTIVE}.
- **Simultaneous events:**
  - Command 0 in the same cycle as ERROR returns the old `faultAddress`, and `stickyFault` stays 1 (set dominates clear).
  - Command 2 in the same cycle as `beginTransactionIn` latches the old `limit`.

## Timing
- `beginTransactionIn` sampled at edge k, limit L≥1: `endTransactionIn` sampled at edges k+1..k+L completes the transaction normally.
- If no end is sampled, `busErrorOut` and `endTransactionOut` are high from edge k+L to k+L+1, exactly one cycle.
- The next `beginTransactionIn` is accepted at edge k+L+1.
- `busErrorOut` always returns low between errors, so a downstream rising-edge detector counts each timeout once.
- CI: zero-cycle latency; all writes land at the edge where `isMyCi` is sampled.
- Reset asserted mid-transaction drops any pending error immediately; no pulse is emitted after reset releases.

## Structure
- Shared package/include `busMonitorPkg` holds:
  - state encodings IDLE=2'd0, ACTIVE=2'd1, ERROR=2'd2;
  - CI command codes CI_A_READ_FAULT=0, CI_A_READ_LIMIT=1, CI_A_WRITE_LIMIT=2, CI_A_READ_STATUS=3;
  - TIMEOUT_WIDTH=16.
- One sub-module, `timeoutCounter`: loadable 16-bit counter with clear, enable and `expire` compare. The FSM and CI decode stay in the top.

## Test plan
1. Reset, then command 1 -> `ciResult`=1024 and `ciDone`=1 in the same cycle; all outputs 0.
2. Command 2 with B=5; begin with address 0x8000_0010; no end -> `busErrorOut` and `endTransactionOut` high exactly in the cycle after edge k+5. Command 0 -> 0x8000_0010; command 3 -> 0 afterwards.
3. L=5, `endTransactionIn` at edge k+5 -> no error pulse, state IDLE; `faultAddress` unchanged.
4. L=0, begin with no end for 5000 cycles -> no error; command 3 -> 0.
5. L=3, two back-to-back timeouts -> two separate one-cycle `busErrorOut` pulses with a low gap between them; the downstream counter reads 2.
6. Command 0 issued in the ERROR cycle -> old address returned and `stickyFault` remains 1. Reset asserted at k+2 with L=5 -> no pulse ever.
